// File: rtl/jtag_tap_sequencer.sv
// TAP controller for the s9234 boundary-scan wrapper: the 16-state TAP FSM, the
// instruction register, DR strobe steering to the BSR or ISR, and TDO muxing.
module jtag_tap_sequencer #(
    parameter int                  IR_WIDTH   = 2,
    parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 2'b01,
    parameter logic [IR_WIDTH-1:0] IR_RESET   = 2'b11
) (
    input  logic                TCLK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                TDO_BSR,
    input  logic                TDO_ISR,
    output logic [IR_WIDTH-1:0] inst,
    output logic                clockdr_bs,
    output logic                shiftdr_bs,
    output logic                updatedr_bs,
    output logic                clockdr_is,
    output logic                shiftdr_is,
    output logic                updatedr_is,
    output logic                TDO,
    output logic                tdo_en,
    output logic [3:0]          tap_state
);

    typedef enum logic [3:0] {
        TLR   = 4'hF,
        RTI   = 4'hC,
        SELDR = 4'h7,
        CAPDR = 4'h6,
        SHDR  = 4'h2,
        EX1DR = 4'h1,
        PAUDR = 4'h3,
        EX2DR = 4'h0,
        UPDDR = 4'h5,
        SELIR = 4'h4,
        CAPIR = 4'hE,
        SHIR  = 4'hA,
        EX1IR = 4'h9,
        PAUIR = 4'hB,
        EX2IR = 4'h8,
        UPDIR = 4'hD
    } tap_state_t;

    tap_state_t          r_state;
    tap_state_t          w_next_state;
    logic [IR_WIDTH-1:0] r_inst;
    logic [IR_WIDTH-1:0] r_ir_shift;
    logic                r_bypass;
    logic                w_sel_bsr;
    logic                w_sel_isr;

    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            r_state <= TLR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            TLR:     w_next_state = TMS ? TLR   : RTI;
            RTI:     w_next_state = TMS ? SELDR : RTI;
            SELDR:   w_next_state = TMS ? SELIR : CAPDR;
            CAPDR:   w_next_state = TMS ? EX1DR : SHDR;
            SHDR:    w_next_state = TMS ? EX1DR : SHDR;
            EX1DR:   w_next_state = TMS ? UPDDR : PAUDR;
            PAUDR:   w_next_state = TMS ? EX2DR : PAUDR;
            EX2DR:   w_next_state = TMS ? UPDDR : SHDR;
            UPDDR:   w_next_state = TMS ? SELDR : RTI;
            SELIR:   w_next_state = TMS ? TLR   : CAPIR;
            CAPIR:   w_next_state = TMS ? EX1IR : SHIR;
            SHIR:    w_next_state = TMS ? EX1IR : SHIR;
            EX1IR:   w_next_state = TMS ? UPDIR : PAUIR;
            PAUIR:   w_next_state = TMS ? EX2IR : PAUIR;
            EX2IR:   w_next_state = TMS ? UPDIR : SHIR;
            UPDIR:   w_next_state = TMS ? SELDR : RTI;
            default: w_next_state = TLR;
        endcase
    end

    // inst only ever changes in UPDIR or TLR, so an aborted IR scan leaves it intact.
    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            r_inst     <= IR_RESET;
            r_ir_shift <= IR_RESET;
            r_bypass   <= 1'b0;
        end else begin
            case (r_state)
                TLR: begin
                    r_inst     <= IR_RESET;
                    r_ir_shift <= IR_RESET;
                end
                CAPIR:   r_ir_shift <= IR_CAPTURE;
                SHIR:    r_ir_shift <= {TDI, r_ir_shift[IR_WIDTH-1:1]};
                UPDIR:   r_inst     <= r_ir_shift;
                CAPDR:   r_bypass   <= 1'b0;
                SHDR:    r_bypass   <= TDI;
                default: ;
            endcase
        end
    end

    // Anything that is not EXTEST, SAMPLE/PRELOAD or INTSCAN routes through bypass.
    assign w_sel_bsr = (r_inst == IR_WIDTH'(0)) || (r_inst == IR_WIDTH'(1));
    assign w_sel_isr = (r_inst == IR_WIDTH'(2));

    always_comb begin
        clockdr_bs  = 1'b0;
        shiftdr_bs  = 1'b0;
        updatedr_bs = 1'b0;
        clockdr_is  = 1'b0;
        shiftdr_is  = 1'b0;
        updatedr_is = 1'b0;
        TDO         = 1'b0;
        tdo_en      = 1'b0;
        if (w_sel_bsr) begin
            clockdr_bs  = (r_state == CAPDR) || (r_state == SHDR);
            shiftdr_bs  = (r_state == SHDR);
            updatedr_bs = (r_state == UPDDR);
        end
        if (w_sel_isr) begin
            clockdr_is  = (r_state == CAPDR) || (r_state == SHDR);
            shiftdr_is  = (r_state == SHDR);
            updatedr_is = (r_state == UPDDR);
        end
        if (r_state == SHIR) begin
            TDO    = r_ir_shift[0];
            tdo_en = 1'b1;
        end else if (r_state == SHDR) begin
            tdo_en = 1'b1;
            if (w_sel_bsr) begin
                TDO = TDO_BSR;
            end else if (w_sel_isr) begin
                TDO = TDO_ISR;
            end else begin
                TDO = r_bypass;
            end
        end
    end

    assign inst      = r_inst;
    assign tap_state = r_state;

endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// Directed bench for jtag_tap_sequencer: a table-driven TAP model checked every
// cycle, plus literal expectations for the documented scan scenarios.
module tb_jtag_tap_sequencer;

    logic       TCLK = 1'b0;
    logic       TRST;
    logic       TMS;
    logic       TDI;
    logic       TDO_BSR;
    logic       TDO_ISR;
    logic [1:0] inst;
    logic       clockdr_bs, shiftdr_bs, updatedr_bs;
    logic       clockdr_is, shiftdr_is, updatedr_is;
    logic       TDO;
    logic       tdo_en;
    logic [3:0] tap_state;

    jtag_tap_sequencer dut (
        .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
        .TDO_BSR(TDO_BSR), .TDO_ISR(TDO_ISR), .inst(inst),
        .clockdr_bs(clockdr_bs), .shiftdr_bs(shiftdr_bs), .updatedr_bs(updatedr_bs),
        .clockdr_is(clockdr_is), .shiftdr_is(shiftdr_is), .updatedr_is(updatedr_is),
        .TDO(TDO), .tdo_en(tdo_en), .tap_state(tap_state)
    );

    // clock
    initial forever #5 TCLK = ~TCLK;

    localparam int S_TLR = 15, S_RTI = 12, S_SELDR = 7, S_CAPDR = 6, S_SHDR = 2;
    localparam int S_EX1DR = 1, S_PAUDR = 3, S_EX2DR = 0, S_UPDDR = 5;
    localparam int S_SELIR = 4, S_CAPIR = 14, S_SHIR = 10, S_EX1IR = 9;
    localparam int S_PAUIR = 11, S_EX2IR = 8, S_UPDIR = 13;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // model: transition table plus integer IR / bypass contents
    int nx[16][2];
    int m_st   = S_TLR;
    int m_inst = 3;
    int m_irsh = 3;
    int m_byp  = 0;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 0 = boundary-scan chain, 1 = internal-scan chain, 2 = bypass
    function automatic int chain_of(input int ins);
        if (ins <= 1) return 0;
        if (ins == 2) return 1;
        return 2;
    endfunction

    always @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            m_st = S_TLR; m_inst = 3; m_irsh = 3; m_byp = 0;
        end else begin
            if (m_st == S_TLR)   begin m_inst = 3; m_irsh = 3; end
            if (m_st == S_CAPIR) m_irsh = 1;
            if (m_st == S_SHIR)  m_irsh = (m_irsh >> 1) + (TDI ? 2 : 0);
            if (m_st == S_UPDIR) m_inst = m_irsh;
            if (m_st == S_CAPDR) m_byp = 0;
            if (m_st == S_SHDR)  m_byp = TDI;
            m_st = nx[m_st][TMS];
        end
    end

    // compare process
    always @(negedge TCLK) begin
        if (chk_en) begin
            int ch, e_tdo;
            bit cap, shf, upd;
            #1;
            ch  = chain_of(m_inst);
            cap = (m_st == S_CAPDR) || (m_st == S_SHDR);
            shf = (m_st == S_SHDR);
            upd = (m_st == S_UPDDR);
            e_tdo = 0;
            if (m_st == S_SHIR) e_tdo = m_irsh % 2;
            if (m_st == S_SHDR) e_tdo = (ch == 0) ? int'(TDO_BSR) : (ch == 1) ? int'(TDO_ISR) : m_byp;
            cmp("tap_state", tap_state, m_st);
            cmp("inst", inst, m_inst);
            cmp("clockdr_bs", clockdr_bs, int'(cap && ch == 0));
            cmp("shiftdr_bs", shiftdr_bs, int'(shf && ch == 0));
            cmp("updatedr_bs", updatedr_bs, int'(upd && ch == 0));
            cmp("clockdr_is", clockdr_is, int'(cap && ch == 1));
            cmp("shiftdr_is", shiftdr_is, int'(shf && ch == 1));
            cmp("updatedr_is", updatedr_is, int'(upd && ch == 1));
            cmp("tdo", TDO, e_tdo);
            cmp("tdo_en", tdo_en, int'(m_st == S_SHIR || m_st == S_SHDR));
        end
    end

    // driver tasks: inputs change on the falling edge, return 2 time units after the rise
    task automatic step(input logic tms, input logic tdi);
        @(negedge TCLK);
        TMS     = tms;
        TDI     = tdi;
        TDO_BSR = 1'($urandom_range(0, 1));
        TDO_ISR = 1'($urandom_range(0, 1));
        @(posedge TCLK);
        #2;
    endtask

    task automatic ir_scan(input logic [1:0] b);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        step(0, b[0]); step(1, b[1]); step(1, 0); step(0, 0);
    endtask

    task automatic dr_scan(input int n, output int sh_bs, output int sh_is,
                           output int up_bs, output int up_is);
        sh_bs = 0; sh_is = 0; up_bs = 0; up_is = 0;
        step(1, 0); step(0, 0);
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) step(0, 1'($urandom_range(0, 1)));
            else       step(1, 0);
            sh_bs += int'(shiftdr_bs); sh_is += int'(shiftdr_is);
            up_bs += int'(updatedr_bs); up_is += int'(updatedr_is);
        end
        step(0, 0);
    endtask

    initial begin
        int a, b, c, d;
        nx[S_TLR]   = '{S_RTI,   S_TLR};
        nx[S_RTI]   = '{S_RTI,   S_SELDR};
        nx[S_SELDR] = '{S_CAPDR, S_SELIR};
        nx[S_CAPDR] = '{S_SHDR,  S_EX1DR};
        nx[S_SHDR]  = '{S_SHDR,  S_EX1DR};
        nx[S_EX1DR] = '{S_PAUDR, S_UPDDR};
        nx[S_PAUDR] = '{S_PAUDR, S_EX2DR};
        nx[S_EX2DR] = '{S_SHDR,  S_UPDDR};
        nx[S_UPDDR] = '{S_RTI,   S_SELDR};
        nx[S_SELIR] = '{S_CAPIR, S_TLR};
        nx[S_CAPIR] = '{S_SHIR,  S_EX1IR};
        nx[S_SHIR]  = '{S_SHIR,  S_EX1IR};
        nx[S_EX1IR] = '{S_PAUIR, S_UPDIR};
        nx[S_PAUIR] = '{S_PAUIR, S_EX2IR};
        nx[S_EX2IR] = '{S_SHIR,  S_UPDIR};
        nx[S_UPDIR] = '{S_RTI,   S_SELDR};

        // reset
        TRST = 1; TMS = 0; TDI = 0; TDO_BSR = 0; TDO_ISR = 0;
        repeat (2) @(posedge TCLK);
        #2;
        cmp("reset_state", tap_state, 4'hF);
        cmp("reset_inst", inst, 2'b11);
        cmp("reset_tdo_en", int'(tdo_en) + int'(TDO), 0);
        @(negedge TCLK);
        TRST = 0;
        chk_en = 1;

        // 1: into RTI
        step(0, 0);
        cmp("t1_state", tap_state, 4'hC);
        cmp("t1_inst", inst, 2'b11);
        cmp("t1_strobes", {clockdr_bs, shiftdr_bs, updatedr_bs, clockdr_is, shiftdr_is, updatedr_is}, 0);

        // 2: IR scan loading INTSCAN
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        cmp("t2_shir", tap_state, 4'hA);
        cmp("t2_tdo0", TDO, 1);
        step(0, 0);
        cmp("t2_tdo1", TDO, 0);
        step(1, 1); step(1, 0);
        cmp("t2_updir_inst_old", inst, 2'b11);
        step(0, 0);
        cmp("t2_inst", inst, 2'b10);

        // 3: ISR scan of three shift cycles
        dr_scan(3, a, b, c, d);
        cmp("t3_shift_is", b, 3);
        cmp("t3_update_is", d, 1);
        cmp("t3_bs_quiet", a + c, 0);

        // 5: five TMS=1 from PAUDR reach TLR
        step(1, 0); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
        cmp("t5_paudr", tap_state, 4'h3);
        repeat (5) step(1, 0);
        cmp("t5_tlr", tap_state, 4'hF);
        cmp("t5_inst_pending", inst, 2'b10);
        step(1, 0);
        cmp("t5_inst_reset", inst, 2'b11);
        step(0, 0);

        // 4: bypass, TDI 1,0,1,1
        step(1, 0); step(0, 0); step(0, 0);
        cmp("t4_tdo0", TDO, 0);
        step(0, 1);
        cmp("t4_tdo1", TDO, 1);
        step(0, 0);
        cmp("t4_tdo2", TDO, 0);
        step(0, 1);
        cmp("t4_tdo3", TDO, 1);
        step(1, 1); step(1, 0); step(0, 0);

        // EXTEST routes to the boundary chain
        ir_scan(2'b00);
        cmp("extest_inst", inst, 2'b00);
        dr_scan(4, a, b, c, d);
        cmp("extest_shift_bs", a, 4);
        cmp("extest_update_bs", c, 1);
        cmp("extest_is_quiet", b + d, 0);

        // 6: reset in the middle of an IR scan
        ir_scan(2'b10);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0); step(0, 1);
        cmp("t6_shir", tap_state, 4'hA);
        cmp("t6_inst_kept", inst, 2'b10);
        TRST = 1;
        #1;
        cmp("t6_state", tap_state, 4'hF);
        cmp("t6_inst", inst, 2'b11);
        @(posedge TCLK);
        @(negedge TCLK);
        TRST = 0;
        step(0, 0);
        cmp("t6_rti", tap_state, 4'hC);
        step(0, 0);

        // report
        @(negedge TCLK);
        #3;
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
